reg_file_wb: RTL

// - Register file that consumes the write-back stage output: takes WriteData,

---
 rtl/reg_file_wb_if.sv | 33 +++
 rtl/reg_file_wb.sv | 118 +++++++++++
 2 files changed

// File: rtl/reg_file_wb_if.sv
// Bus between the pipeline and the register file: write-back port, two decode
// read ports, issue port into the pending-write scoreboard, and hazard/error flags.
//   master : pipeline side (drives WB, read indices and issue; receives data/flags)
//   slave  : register file side
interface reg_file_wb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              IssueValid;
  logic [ADDR_W-1:0] IssueRegister;
  logic              Hazard1;
  logic              Hazard2;
  logic              Overflow;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
           IssueValid, IssueRegister,
    input  ReadData1, ReadData2, Hazard1, Hazard2, Overflow
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
           IssueValid, IssueRegister,
    output ReadData1, ReadData2, Hazard1, Hazard2, Overflow
  );
endinterface

// File: rtl/reg_file_wb.sv
// Register file fed by the write-back stage, with same-cycle write-to-read
// bypass, hardwired-zero register 0 and a per-register pending-write scoreboard
// that flags read-after-write hazards to the decode stall logic.
// Ports:
//   Clk    : rising-edge clock
//   Rst_n  : asynchronous active-low reset (clears data, counters, Overflow)
//   bus    : slave side of reg_file_wb_if
//            in : RegWrite, WriteRegister, WriteData, ReadRegister1/2,
//                 IssueValid, IssueRegister
//            out: ReadData1/2, Hazard1/2 (combinational), Overflow (registered, sticky)
module reg_file_wb #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 2
) (
  input  logic          Clk,
  input  logic          Rst_n,
  reg_file_wb_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [DATA_W-1:0] regs    [NUM_REGS];
  logic [CNT_W-1:0]  cnt     [NUM_REGS];
  logic [CNT_W-1:0]  cntNext [NUM_REGS];
  logic              overflowQ;

  logic inc;
  logic dec;
  logic sameIdx;
  logic incSat;
  logic rel1;
  logic rel2;

  // Scoreboard events; index 0 never tracks or stores anything
  assign inc     = bus.IssueValid && (bus.IssueRegister != '0);
  assign dec     = bus.RegWrite && (bus.WriteRegister != '0);
  assign sameIdx = (bus.IssueRegister == bus.WriteRegister);
  // A matching write-back cancels the issue, so only an unpaired issue can saturate
  assign incSat  = inc && !(dec && sameIdx) && (cnt[bus.IssueRegister] == CntMax);

  // Register storage
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (dec) begin
      regs[bus.WriteRegister] <= bus.WriteData;
    end
  end

  // Next pending count per register: saturates at max, floors at zero
  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      cntNext[i] = cnt[i];
      if (inc && (bus.IssueRegister == ADDR_W'(i)) &&
          !(dec && (bus.WriteRegister == ADDR_W'(i)))) begin
        if (cnt[i] != CntMax) begin
          cntNext[i] = cnt[i] + CNT_W'(1);
        end
      end else if (dec && (bus.WriteRegister == ADDR_W'(i)) &&
                   !(inc && (bus.IssueRegister == ADDR_W'(i)))) begin
        if (cnt[i] != '0) begin
          cntNext[i] = cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Scoreboard counters and sticky overflow
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        cnt[i] <= '0;
      end
      overflowQ <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        cnt[i] <= cntNext[i];
      end
      if (incSat) begin
        overflowQ <= 1'b1;
      end
    end
  end

  assign bus.Overflow = overflowQ;

  // Read ports: zero register, then WB bypass, then stored value
  always_comb begin
    bus.ReadData1 = regs[bus.ReadRegister1];
    if (bus.ReadRegister1 == '0) begin
      bus.ReadData1 = '0;
    end else if (bus.RegWrite && (bus.WriteRegister == bus.ReadRegister1)) begin
      bus.ReadData1 = bus.WriteData;
    end
  end

  always_comb begin
    bus.ReadData2 = regs[bus.ReadRegister2];
    if (bus.ReadRegister2 == '0) begin
      bus.ReadData2 = '0;
    end else if (bus.RegWrite && (bus.WriteRegister == bus.ReadRegister2)) begin
      bus.ReadData2 = bus.WriteData;
    end
  end

  // Hazards: a write-back this cycle releases its own pending entry for the reader.
  // Compared rather than subtracted so an untracked write never wraps into a stall.
  assign rel1 = dec && (bus.WriteRegister == bus.ReadRegister1);
  assign rel2 = dec && (bus.WriteRegister == bus.ReadRegister2);

  assign bus.Hazard1 = (bus.ReadRegister1 != '0) && (cnt[bus.ReadRegister1] > CNT_W'(rel1));
  assign bus.Hazard2 = (bus.ReadRegister2 != '0) && (cnt[bus.ReadRegister2] > CNT_W'(rel2));

endmodule
